// File: rtl/uart_pkg.sv
// Shared types and sampling constants for the UART receive path.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_t;

  localparam int OVER_SAMPLE = 16;
  localparam int MID_SAMPLE  = 7;
  localparam int LAST_SAMPLE = OVER_SAMPLE - 1;

endpackage

// File: rtl/rx_sync_fifo.sv
// First-word fall-through FIFO with array storage and a registered head word.
module rx_sync_fifo #(
  parameter int SIZE_DATA  = 8,
  parameter int SIZE_DEPTH = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_wr_en,
  input  logic [SIZE_DATA-1:0] i_wr_data,
  input  logic                 i_rd_en,
  output logic [SIZE_DATA-1:0] o_rd_data,
  output logic                 o_empty,
  output logic                 o_full
);

  localparam int AW = $clog2(SIZE_DEPTH);

  logic [SIZE_DATA-1:0] mem [SIZE_DEPTH];
  logic [AW:0]          wr_ptr_reg, wr_ptr_next;
  logic [AW:0]          rd_ptr_reg, rd_ptr_next;
  logic [SIZE_DATA-1:0] rd_data_reg;
  logic                 wr_go, rd_go, head_bypass;

  assign o_empty = (wr_ptr_reg == rd_ptr_reg);
  assign o_full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);

  // A full FIFO is never empty, so a valid pop always frees the slot being written.
  assign rd_go = i_rd_en && !o_empty;
  assign wr_go = i_wr_en && (!o_full || rd_go);

  assign wr_ptr_next = wr_ptr_reg + (AW+1)'(wr_go);
  assign rd_ptr_next = rd_ptr_reg + (AW+1)'(rd_go);

  // The incoming word becomes the head when it lands where the next head is read.
  assign head_bypass = wr_go && (wr_ptr_reg[AW-1:0] == rd_ptr_next[AW-1:0]);

  always_ff @(posedge i_clk) begin
    if (wr_go) begin
      mem[wr_ptr_reg[AW-1:0]] <= i_wr_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      rd_data_reg <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      if (head_bypass) begin
        rd_data_reg <= i_wr_data;
      end else if (rd_go) begin
        rd_data_reg <= mem[rd_ptr_next[AW-1:0]];
      end
    end
  end

  assign o_rd_data = rd_data_reg;

endmodule

// File: rtl/uart_rx_block.sv
// 8N1 UART receiver: 16x oversampling from a free-running tick, FIFO-buffered
// bytes and sticky framing/overrun flags for the host.
module uart_rx_block
  import uart_pkg::*;
#(
  parameter int SIZE_DATA      = 8,
  parameter int BAUDRATE_VALUE = 325,
  parameter int SIZE_DEPTH     = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_rx_serial,
  input  logic                 i_rd_en,
  input  logic                 i_clr_err,
  output logic [SIZE_DATA-1:0] o_rx_data,
  output logic                 o_rx_done,
  output logic                 o_fifo_empty,
  output logic                 o_fifo_full,
  output logic                 o_frame_err,
  output logic                 o_overrun
);

  localparam int TICK_W      = (BAUDRATE_VALUE > 0) ? $clog2(BAUDRATE_VALUE + 1) : 1;
  localparam int N_W         = (SIZE_DATA > 1) ? $clog2(SIZE_DATA) : 1;
  localparam int SYNC_STAGES = 2;

  logic [TICK_W-1:0]    tick_cnt_reg;
  logic                 w_stick;
  logic                 sync_reg [SYNC_STAGES];
  logic                 rx_s;
  rx_state_t            state_reg, state_next;
  logic [3:0]           s_cnt_reg, s_cnt_next;
  logic [N_W-1:0]       n_cnt_reg, n_cnt_next;
  logic [SIZE_DATA-1:0] data_sr_reg, data_sr_next;
  logic                 stop_sample;
  logic                 push, frame_err_set, overrun_set;
  logic                 rx_done_reg, frame_err_reg, overrun_reg;
  logic                 fifo_full;

  assign w_stick = (tick_cnt_reg == TICK_W'(BAUDRATE_VALUE));

  always_ff @(posedge i_clk) begin
    if (i_rst || w_stick) begin
      tick_cnt_reg <= '0;
    end else begin
      tick_cnt_reg <= tick_cnt_reg + TICK_W'(1);
    end
  end

  // Synchronizer chain idles high so reset never looks like a start bit.
  generate
    for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      if (gi == 0) begin : g_first
        always_ff @(posedge i_clk) begin
          if (i_rst) sync_reg[gi] <= 1'b1;
          else       sync_reg[gi] <= i_rx_serial;
        end
      end else begin : g_next
        always_ff @(posedge i_clk) begin
          if (i_rst) sync_reg[gi] <= 1'b1;
          else       sync_reg[gi] <= sync_reg[gi-1];
        end
      end
    end
  endgenerate

  assign rx_s = sync_reg[SYNC_STAGES-1];

  assign stop_sample = (state_reg == STOP) && w_stick && (s_cnt_reg == 4'(LAST_SAMPLE));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg   <= IDLE;
      s_cnt_reg   <= '0;
      n_cnt_reg   <= '0;
      data_sr_reg <= '0;
    end else begin
      state_reg   <= state_next;
      s_cnt_reg   <= s_cnt_next;
      n_cnt_reg   <= n_cnt_next;
      data_sr_reg <= data_sr_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    s_cnt_next    = s_cnt_reg;
    n_cnt_next    = n_cnt_reg;
    data_sr_next  = data_sr_reg;
    push          = 1'b0;
    frame_err_set = 1'b0;
    overrun_set   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!rx_s) begin
          s_cnt_next = '0;
          state_next = START;
        end
      end
      START: begin
        if (w_stick) begin
          if (s_cnt_reg == 4'(MID_SAMPLE)) begin
            if (!rx_s) begin
              s_cnt_next = '0;
              n_cnt_next = '0;
              state_next = DATA;
            end else begin
              state_next = IDLE;
            end
          end else begin
            s_cnt_next = s_cnt_reg + 4'd1;
          end
        end
      end
      DATA: begin
        if (w_stick) begin
          if (s_cnt_reg == 4'(LAST_SAMPLE)) begin
            s_cnt_next   = '0;
            data_sr_next = {rx_s, data_sr_reg[SIZE_DATA-1:1]};
            if (n_cnt_reg == N_W'(SIZE_DATA - 1)) begin
              state_next = STOP;
            end else begin
              n_cnt_next = n_cnt_reg + N_W'(1);
            end
          end else begin
            s_cnt_next = s_cnt_reg + 4'd1;
          end
        end
      end
      STOP: begin
        if (w_stick) begin
          if (stop_sample) begin
            s_cnt_next = '0;
            state_next = IDLE;
            // A same-cycle host read frees a slot even when the FIFO is full.
            if (!rx_s) begin
              frame_err_set = 1'b1;
            end else if (fifo_full && !i_rd_en) begin
              overrun_set = 1'b1;
            end else begin
              push = 1'b1;
            end
          end else begin
            s_cnt_next = s_cnt_reg + 4'd1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rx_done_reg   <= 1'b0;
      frame_err_reg <= 1'b0;
      overrun_reg   <= 1'b0;
    end else begin
      rx_done_reg <= push;
      if (frame_err_set)  frame_err_reg <= 1'b1;
      else if (i_clr_err) frame_err_reg <= 1'b0;
      if (overrun_set)    overrun_reg <= 1'b1;
      else if (i_clr_err) overrun_reg <= 1'b0;
    end
  end

  rx_sync_fifo #(
    .SIZE_DATA  (SIZE_DATA),
    .SIZE_DEPTH (SIZE_DEPTH)
  ) u_fifo (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_wr_en   (push),
    .i_wr_data (data_sr_reg),
    .i_rd_en   (i_rd_en),
    .o_rd_data (o_rx_data),
    .o_empty   (o_fifo_empty),
    .o_full    (fifo_full)
  );

  assign o_fifo_full = fifo_full;
  assign o_rx_done   = rx_done_reg;
  assign o_frame_err = frame_err_reg;
  assign o_overrun   = overrun_reg;

endmodule

// File: tb/tb_uart_rx_block.sv
// Bench for uart_rx_block: vector table, hand-built corner sequences and
// random frames against a queue-based model of the receive FIFO and flags.
module tb_uart_rx_block;

  localparam int BAUD     = 3;
  localparam int BIT_CLKS = (BAUD + 1) * 16;
  localparam int DEPTH    = 16;

  logic       i_clk = 1'b0;
  logic       i_rst, i_rx_serial, i_rd_en, i_clr_err;
  logic [7:0] o_rx_data;
  logic       o_rx_done, o_fifo_empty, o_fifo_full, o_frame_err, o_overrun;

  int pass_cnt = 0;
  int total_cnt = 0;
  int done_cnt = 0;

  always #5 i_clk = ~i_clk;

  uart_rx_block #(
    .SIZE_DATA      (8),
    .BAUDRATE_VALUE (BAUD),
    .SIZE_DEPTH     (DEPTH)
  ) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_rx_serial  (i_rx_serial),
    .i_rd_en      (i_rd_en),
    .i_clr_err    (i_clr_err),
    .o_rx_data    (o_rx_data),
    .o_rx_done    (o_rx_done),
    .o_fifo_empty (o_fifo_empty),
    .o_fifo_full  (o_fifo_full),
    .o_frame_err  (o_frame_err),
    .o_overrun    (o_overrun)
  );

  always @(posedge i_clk) if (o_rx_done) done_cnt <= done_cnt + 1;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       exp_push;
    logic       exp_ferr;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Stop level is held 40 clocks (past the mid-sample) then the line idles high.
  task automatic send_frame(input logic [7:0] d, input logic stop);
    i_rx_serial = 1'b0;
    repeat (BIT_CLKS) @(negedge i_clk);
    for (int b = 0; b < 8; b++) begin
      i_rx_serial = d[b];
      repeat (BIT_CLKS) @(negedge i_clk);
    end
    i_rx_serial = stop;
    repeat (40) @(negedge i_clk);
    i_rx_serial = 1'b1;
    repeat (BIT_CLKS - 40 + 80) @(negedge i_clk);
    $display("frame data=%02h stop=%0d empty=%0d full=%0d ferr=%0d ovr=%0d",
             d, stop, o_fifo_empty, o_fifo_full, o_frame_err, o_overrun);
  endtask

  task automatic pop_check(input string name, input logic [7:0] exp);
    check(name, o_fifo_empty, 1'b0);
    check(name, o_rx_data, exp);
    i_rd_en = 1'b1;
    @(negedge i_clk);
    i_rd_en = 1'b0;
  endtask

  task automatic clear_errors();
    i_clr_err = 1'b1;
    @(negedge i_clk);
    i_clr_err = 1'b0;
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_data"}, o_rx_data, 8'h00);
    check({name, "_done"}, o_rx_done, 1'b0);
    check({name, "_empty"}, o_fifo_empty, 1'b1);
    check({name, "_full"}, o_fifo_full, 1'b0);
    check({name, "_ferr"}, o_frame_err, 1'b0);
    check({name, "_ovr"}, o_overrun, 1'b0);
  endtask

  initial begin
    #(1_500_000 * 10);
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("%0d/%0d checks passed", pass_cnt, total_cnt + 1);
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t       vecs [5];
    int         d0;
    bit         hit;
    logic [7:0] q [$];
    bit         m_ferr, m_ovr;
    logic [7:0] rd, exp_b;
    logic       rs;
    int         npop;

    vecs[0] = '{8'hA5, 1'b1, 1'b1, 1'b0};
    vecs[1] = '{8'h3C, 1'b0, 1'b0, 1'b1};
    vecs[2] = '{8'h00, 1'b1, 1'b1, 1'b0};
    vecs[3] = '{8'hFF, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{8'h81, 1'b0, 1'b0, 1'b1};

    i_rst = 1'b1; i_rx_serial = 1'b1; i_rd_en = 1'b0; i_clr_err = 1'b0;
    repeat (3) @(negedge i_clk);
    check_reset_outputs("reset");
    i_rst = 1'b0;
    repeat (5) @(negedge i_clk);

    // Table-driven single frames
    for (int i = 0; i < 5; i++) begin
      d0 = done_cnt;
      send_frame(vecs[i].data, vecs[i].stop);
      check("vec_done", done_cnt - d0, {31'd0, vecs[i].exp_push});
      check("vec_empty", o_fifo_empty, !vecs[i].exp_push);
      check("vec_ferr", o_frame_err, vecs[i].exp_ferr);
      check("vec_ovr", o_overrun, 1'b0);
      if (vecs[i].exp_push) begin
        pop_check("vec_data", vecs[i].data);
        check("vec_empty_after_rd", o_fifo_empty, 1'b1);
      end
      if (vecs[i].exp_ferr) begin
        clear_errors();
        check("vec_ferr_clr", o_frame_err, 1'b0);
      end
    end

    // Short low glitch is a false start
    d0 = done_cnt;
    i_rx_serial = 1'b0;
    repeat (20) @(negedge i_clk);
    i_rx_serial = 1'b1;
    repeat (200) @(negedge i_clk);
    check("glitch_done", done_cnt - d0, 0);
    check("glitch_empty", o_fifo_empty, 1'b1);
    check("glitch_ferr", o_frame_err, 1'b0);
    check("glitch_ovr", o_overrun, 1'b0);
    send_frame(8'h3C, 1'b1);
    check("glitch_next_done", done_cnt - d0, 1);
    pop_check("glitch_next_data", 8'h3C);

    // Fill to full, then overrun
    d0 = done_cnt;
    for (int i = 0; i < 16; i++) begin
      send_frame(i[7:0], 1'b1);
      if (i == 14) check("fill_not_full", o_fifo_full, 1'b0);
    end
    check("fill_full", o_fifo_full, 1'b1);
    check("fill_ovr_pre", o_overrun, 1'b0);
    send_frame(8'h10, 1'b1);
    check("ovr_flag", o_overrun, 1'b1);
    check("ovr_full", o_fifo_full, 1'b1);
    check("ovr_done", done_cnt - d0, 16);
    for (int i = 0; i < 16; i++) pop_check("ovr_order", i[7:0]);
    check("ovr_drained", o_fifo_empty, 1'b1);
    clear_errors();
    check("ovr_clr", o_overrun, 1'b0);

    // Pop in the same cycle as a push into a full FIFO
    d0 = done_cnt;
    for (int i = 0; i < 16; i++) send_frame(i[7:0], 1'b1);
    hit = 1'b0;
    fork
      send_frame(8'h10, 1'b1);
      begin
        for (int n = 0; n < 12 * BIT_CLKS && !hit; n++) begin
          @(negedge i_clk);
          if (dut.stop_sample) begin
            i_rd_en = 1'b1;
            @(negedge i_clk);
            i_rd_en = 1'b0;
            hit = 1'b1;
          end
        end
      end
    join
    check("simul_timing", hit, 1'b1);
    check("simul_ovr", o_overrun, 1'b0);
    check("simul_full", o_fifo_full, 1'b1);
    check("simul_done", done_cnt - d0, 17);
    for (int i = 1; i <= 16; i++) pop_check("simul_order", i[7:0]);
    check("simul_drained", o_fifo_empty, 1'b1);

    // Reset in the middle of a data bit
    send_frame(8'h42, 1'b1);
    send_frame(8'h99, 1'b0);
    check("mid_pre_empty", o_fifo_empty, 1'b0);
    check("mid_pre_ferr", o_frame_err, 1'b1);
    i_rx_serial = 1'b0;
    repeat (BIT_CLKS * 4 + 10) @(negedge i_clk);
    i_rx_serial = 1'b1;
    i_rst = 1'b1;
    repeat (2) @(negedge i_clk);
    i_rst = 1'b0;
    repeat (4) @(negedge i_clk);
    check_reset_outputs("mid_reset");
    d0 = done_cnt;
    send_frame(8'h5A, 1'b1);
    check("mid_after_done", done_cnt - d0, 1);
    check("mid_after_ferr", o_frame_err, 1'b0);
    pop_check("mid_after_data", 8'h5A);
    check("mid_after_empty", o_fifo_empty, 1'b1);

    // Random frames against the queue model
    m_ferr = 1'b0;
    m_ovr  = 1'b0;
    for (int i = 0; i < 24; i++) begin
      rd = 8'($urandom_range(0, 255));
      rs = ($urandom_range(0, 5) != 0);
      send_frame(rd, rs);
      if (!rs) m_ferr = 1'b1;
      else if (q.size() < DEPTH) q.push_back(rd);
      else m_ovr = 1'b1;
      check("rand_ferr", o_frame_err, m_ferr);
      check("rand_ovr", o_overrun, m_ovr);
      check("rand_empty", o_fifo_empty, q.size() == 0);
      check("rand_full", o_fifo_full, q.size() == DEPTH);
      npop = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 3) : 0;
      for (int k = 0; k < npop; k++) begin
        if (q.size() > 0) begin
          exp_b = q.pop_front();
          pop_check("rand_pop", exp_b);
        end
      end
      if ($urandom_range(0, 4) == 0) begin
        clear_errors();
        m_ferr = 1'b0;
        m_ovr  = 1'b0;
        check("rand_clr_ferr", o_frame_err, 1'b0);
      end
    end
    while (q.size() > 0) begin
      exp_b = q.pop_front();
      pop_check("rand_drain", exp_b);
    end
    check("rand_final_empty", o_fifo_empty, 1'b1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
